mdu_hilo: RTL

Iterative multiply/divide unit with architectural HI/LO registers. It consumes the two read ports of the register bank (RD1 as rs operand, RD2 as rt operand) in the execute stage. It executes MULT/MULTU/DIV/DIVU over WIDTH cycles, and MTHI/MTLO in one cycle. HI/LO are exposed continuously for MFHI/MFLO forwarding back to the register-bank write path.

---
 rtl/mdu_pkg.sv | 19 +
 rtl/mdu_hilo_seq_divider.sv | 60 ++++++
 rtl/mdu_hilo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: opcodes, FSM states, default width.
package mdu_pkg;
  localparam int MDU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } mdu_state_e;
endpackage

// File: rtl/mdu_hilo_seq_divider.sv
// Restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// The next-step quotient/remainder are exported so the final step can retire directly into HI/LO.
module seq_divider
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_nxt,
  output logic [WIDTH-1:0] rem_nxt
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // quo_q starts as the dividend; its MSB feeds the remainder while quotient bits fill from the LSB.
  always_comb begin
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvsr_q};
    fits    = ~diff[WIDTH];
    rem_nxt = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo_q[WIDTH-2:0], fits};
  end

  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    if (load) begin
      rem_d  = '0;
      quo_d  = dividend;
      dvsr_d = divisor;
    end else if (step) begin
      rem_d = rem_nxt;
      quo_d = quo_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end

endmodule

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit plus single-cycle MTHI/MTLO, owning the architectural HI/LO.
// Operands are reduced to magnitudes at start; sign fix-up happens on the retiring step.
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               dzf_q, dzf_d;
  logic [WIDTH-1:0]   araw_q, araw_d;

  logic               signed_op;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_step, prod_fix;
  logic [WIDTH-1:0]   quo_nxt, rem_nxt;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic               div_load, div_step;

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt)
  );

  // prod_q = {partial sum, remaining multiplier bits}; each step adds on the LSB then shifts right.
  always_comb begin
    signed_op = ~op[0];
    a_mag     = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag     = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};
    prod_fix  = qneg_q ? -prod_step : prod_step;
    quo_fix   = qneg_q ? -quo_nxt : quo_nxt;
    rem_fix   = rneg_q ? -rem_nxt : rem_nxt;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dzf_d    = dzf_q;
    araw_d   = araw_q;
    div_load = 1'b0;
    div_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              mcand_d = a_mag;
              prod_d  = {{WIDTH{1'b0}}, b_mag};
              qneg_d  = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              cnt_d   = '0;
              state_d = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              qneg_d   = signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              rneg_d   = signed_op & op_a[WIDTH-1];
              dzf_d    = (op_b == '0);
              araw_d   = op_a;
              cnt_d    = '0;
              state_d  = ST_DIV;
            end
            OP_MTHI: begin
              hi_d   = op_a;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = op_a;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = prod_fix[WIDTH-1:0];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        div_step = 1'b1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Zero divisor leaves the raw dividend in HI rather than the magnitude remainder.
          hi_d    = dzf_q ? araw_q : rem_fix;
          lo_d    = dzf_q ? '1 : quo_fix;
          dz_d    = dzf_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      prod_q  <= '0;
      mcand_q <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dzf_q   <= 1'b0;
      araw_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dzf_q   <= dzf_d;
      araw_q  <= araw_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
